// File: rtl/line_col3_gen.sv
// Raster line buffer emitting the vertical 3-pixel column ending at each
// pixel from row 2 onward; feeds the three-input median sorter.
module line_col3_gen #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_vld,
   input  logic                       in_sof,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       out_vld,
   output logic [DATA_W-1:0]          out_data1,
   output logic [DATA_W-1:0]          out_data2,
   output logic [DATA_W-1:0]          out_data3,
   output logic [$clog2(IMG_W)-1:0]   out_col,
   output logic [$clog2(IMG_H)-1:0]   out_row,
   output logic                       frame_done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] LAST_C = CW'(IMG_W - 1);
   localparam logic [RW-1:0] LAST_R = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ONE_R  = RW'(1);

   typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     row_q, row_d;
   logic              vld_q, fd_q;
   logic [DATA_W-1:0] d1_q, d2_q, d3_q;
   logic [CW-1:0]     ocol_q;
   logic [RW-1:0]     orow_q;

   logic [DATA_W-1:0] linea_q [IMG_W];
   logic [DATA_W-1:0] lineb_q [IMG_W];

   logic          acc, emit, last_c, last_r;
   logic [CW-1:0] c;
   logic [RW-1:0] r;

   // An sof pixel is always (0,0), regardless of where the counters are.
   always_comb begin
      acc     = in_vld && (in_sof || (state_q != IDLE));
      c       = in_sof ? '0 : col_q;
      r       = in_sof ? '0 : row_q;
      last_c  = (c == LAST_C);
      last_r  = (r == LAST_R);
      emit    = acc && !in_sof && (state_q == RUN);
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      if (acc) begin
         col_d = last_c ? '0 : c + CW'(1);
         row_d = last_c ? (last_r ? '0 : r + RW'(1)) : r;
         unique case (1'b1)
            in_sof: state_d = FILL;
            (state_q == FILL) && (r == ONE_R) && last_c: state_d = RUN;
            emit && last_r && last_c: state_d = IDLE;
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         vld_q   <= 1'b0;
         fd_q    <= 1'b0;
         d1_q    <= '0;
         d2_q    <= '0;
         d3_q    <= '0;
         ocol_q  <= '0;
         orow_q  <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         vld_q   <= emit;
         fd_q    <= emit && last_r && last_c;
         if (emit) begin
            d1_q   <= lineb_q[c];
            d2_q   <= linea_q[c];
            d3_q   <= in_data;
            ocol_q <= c;
            orow_q <= r;
         end
      end
   end

   // Line memories are not reset; FILL rewrites both rows before use.
   always_ff @(posedge clk) begin
      if (acc) begin
         lineb_q[c] <= linea_q[c];
         linea_q[c] <= in_data;
      end
   end

   assign out_vld    = vld_q;
   assign frame_done = fd_q;
   assign out_data1  = d1_q;
   assign out_data2  = d2_q;
   assign out_data3  = d3_q;
   assign out_col    = ocol_q;
   assign out_row    = orow_q;

endmodule

// File: tb/tb_line_col3_gen.sv
// Bench for line_col3_gen: image-array reference model checked every
// cycle, plus hand-computed expectations for the 4x4 test frames.
module tb_line_col3_gen;

   localparam int W = 4;
   localparam int H = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_vld = 1'b0;
   logic       in_sof = 1'b0;
   logic [7:0] in_data = '0;
   logic       out_vld, frame_done;
   logic [7:0] out_data1, out_data2, out_data3;
   logic [1:0] out_col, out_row;

   line_col3_gen #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
      .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_sof(in_sof),
      .in_data(in_data), .out_vld(out_vld), .out_data1(out_data1),
      .out_data2(out_data2), .out_data3(out_data3), .out_col(out_col),
      .out_row(out_row), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h",
                  name, $time, act, exp);
      end
   endtask

   // Reference model: the frame as a 2-D image; the column is just
   // img[r-2][c], img[r-1][c], img[r][c] once r >= 2.
   logic [7:0] img [H][W];
   bit         act_f;
   int         mr, mc;
   bit         e_vld, e_fd;
   logic [7:0] e_d1, e_d2, e_d3;
   int         e_col, e_row;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_f = 0; mr = 0; mc = 0;
         e_vld = 0; e_fd = 0;
         e_d1 = 0; e_d2 = 0; e_d3 = 0;
         e_col = 0; e_row = 0;
      end else begin
         e_vld = 0;
         e_fd  = 0;
         if (in_vld && (in_sof || act_f)) begin
            if (in_sof) begin
               mr = 0; mc = 0; act_f = 1;
            end
            img[mr][mc] = in_data;
            if (mr >= 2) begin
               e_vld = 1;
               e_d1  = img[mr-2][mc];
               e_d2  = img[mr-1][mc];
               e_d3  = in_data;
               e_col = mc;
               e_row = mr;
               e_fd  = (mr == H-1) && (mc == W-1);
            end
            mc++;
            if (mc == W) begin
               mc = 0;
               mr++;
               if (mr == H) begin
                  mr = 0;
                  act_f = 0;
               end
            end
         end
      end
   end

   int n_out = 0;
   int n_fd = 0;
   int first_col, last_col;
   int first_rc, last_fd;

   always @(negedge clk) begin
      chk("out_vld", out_vld, e_vld);
      chk("frame_done", frame_done, e_fd);
      chk("out_data1", out_data1, e_d1);
      chk("out_data2", out_data2, e_d2);
      chk("out_data3", out_data3, e_d3);
      chk("out_col", out_col, e_col);
      chk("out_row", out_row, e_row);
      if (out_vld) begin
         if (n_out == 0) begin
            first_col = {out_data1, out_data2, out_data3};
            first_rc  = {out_row, out_col};
         end
         last_col = {out_data1, out_data2, out_data3};
         last_fd  = frame_done;
         n_out++;
      end
      if (frame_done) n_fd++;
   end

   task automatic pix(input bit sof, input logic [7:0] d);
      @(posedge clk); #1;
      in_vld  = 1'b1;
      in_sof  = sof;
      in_data = d;
   endtask

   task automatic gap();
      @(posedge clk); #1;
      in_vld  = 1'b0;
      in_sof  = 1'b0;
      in_data = 8'($urandom);
   endtask

   task automatic frame(input int base, input int gmax, input int stop_r,
                        input int stop_c, input bit rnd);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            if (r * W + c <= stop_r * W + stop_c) begin
               int g = (gmax > 0) ? $urandom_range(gmax, 0) : 0;
               for (int k = 0; k < g; k++) gap();
               pix(r == 0 && c == 0,
                   rnd ? 8'($urandom) : 8'(base + r * 16 + c));
            end
         end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) gap();
   endtask

   task automatic clr();
      n_out = 0;
      n_fd  = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: timeout reached, expected finish");
      $fatal(1);
   end

   initial begin
      #12;
      chk("rst out_vld", out_vld, 0);
      chk("rst out_data1", out_data1, 0);
      chk("rst out_data3", out_data3, 0);
      chk("rst out_row", out_row, 0);
      rst_n = 1'b1;
      idle(2);

      // 1: continuous frame
      clr();
      frame(0, 0, H-1, W-1, 0);
      idle(3);
      chk("s1 count", n_out, 8);
      chk("s1 fd count", n_fd, 1);
      chk("s1 first", first_col, 32'h001020);
      chk("s1 first pos", first_rc, 4'b1000);
      chk("s1 last", last_col, 32'h132333);
      chk("s1 last fd", last_fd, 1);

      // 2: random gaps
      clr();
      frame(0, 3, H-1, W-1, 0);
      idle(3);
      chk("s2 count", n_out, 8);
      chk("s2 first", first_col, 32'h001020);
      chk("s2 last", last_col, 32'h132333);

      // 3: stray pixels in idle
      clr();
      for (int k = 0; k < 5; k++) pix(0, 8'($urandom));
      idle(2);
      chk("s3 stray", n_out, 0);
      frame(0, 1, H-1, W-1, 0);
      idle(3);
      chk("s3 count", n_out, 8);
      chk("s3 first", first_col, 32'h001020);

      // 4: sof re-asserted at (2,2)
      clr();
      frame(0, 0, 2, 1, 0);
      frame(8'h80, 0, H-1, W-1, 0);
      idle(3);
      chk("s4 fd count", n_fd, 1);
      chk("s4 count", n_out, 2 + 8);
      clr();
      frame(8'h80, 0, 2, 0, 0);
      idle(2);
      chk("s4 first", first_col, 32'h8090A0);
      chk("s4 first pos", first_rc, 4'b1000);
      frame(0, 0, H-1, W-1, 0);
      idle(2);

      // 5: reset at (3,1)
      clr();
      frame(0, 0, 3, 1, 0);
      @(posedge clk); #2;
      in_vld = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("s5 vld", out_vld, 0);
      chk("s5 d1", out_data1, 0);
      chk("s5 d2", out_data2, 0);
      chk("s5 d3", out_data3, 0);
      chk("s5 col", out_col, 0);
      chk("s5 row", out_row, 0);
      @(negedge clk);
      rst_n = 1'b1;
      clr();
      for (int k = 0; k < 6; k++) pix(0, 8'($urandom));
      idle(2);
      chk("s5 silent", n_out, 0);
      frame(0, 2, H-1, W-1, 0);
      idle(3);
      chk("s5 count", n_out, 8);
      chk("s5 last", last_col, 32'h132333);

      // 6: back-to-back frames
      clr();
      frame(0, 0, H-1, W-1, 0);
      frame(8'h40, 0, H-1, W-1, 0);
      idle(3);
      chk("s6 fd count", n_fd, 2);
      chk("s6 count", n_out, 16);
      chk("s6 last", last_col, 32'h536373);

      // random data and gaps, model-only checking
      for (int f = 0; f < 20; f++) begin
         frame(0, $urandom_range(2, 0), H-1, W-1, 1);
         if ($urandom_range(1, 0) == 1) idle($urandom_range(3, 0));
      end
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
